rom_dl_arbiter: RTL and testbench

//  Shares the single-port cartridge ROM block RAM between the HPS ioctl download stream (writes) and the

---
 rtl/rom_dl_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_rom_dl_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter
//  The cartridge ROM block RAM has a single port. This block shares it between two users:
//  the HPS ioctl download stream, which writes, and the console cartridge fetch port, which
//  reads. Fetches take priority. A download byte that cannot be written yet waits in a
//  one-entry holding register, and dl_wait throttles the HPS until that byte is committed.
//  The block also tracks the loaded ROM size and pulses load_done once the load has finished.
// Parameters
//  AW       ROM address width (2**AW bytes)
//  MEM_LAT  RAM read latency in clk cycles (1..3)
// Ports
//  clk, reset              clock; asynchronous active-high reset
//  dl_active               download in progress
//  dl_wr/dl_addr/dl_data   one-cycle download byte strobe with address and data
//  dl_wait                 backpressure to the HPS (holding register occupied)
//  rd_req/rd_addr          fetch request and address, held until rd_ack
//  rd_ack/rd_data          one-cycle fetch completion pulse; the byte is held until the next ack
//  mem_addr/mem_we/mem_din RAM address, write enable and write data
//  mem_dout                RAM read data, valid MEM_LAT cycles after the address
//  rom_size                highest committed in-range write address + 1
//  load_done               one-cycle pulse after dl_active falls and the pending byte is written
module rom_dl_arbiter #(
    parameter int AW      = 15,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic [AW:0]   rom_size,
    output logic          load_done
);

    localparam int         HI_W         = 25 - AW;
    localparam logic [1:0] LAT_C        = 2'(MEM_LAT);
    localparam logic [2:0] STARVE_MAX_C = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [1:0]    cnt_r, cnt_s;
    logic [2:0]    starve_r, starve_s;
    logic          hv_r;
    logic [AW-1:0] ha_r;
    logic [7:0]    hd_r;
    logic [AW-1:0] rd_addr_r;
    logic          rd_ack_r;
    logic [7:0]    rd_data_r;
    logic [AW:0]   rom_size_r, size_base_s, size_cand_s, size_next_s;
    logic          dl_active_d_r, done_pend_r, load_done_r;
    logic          in_range_s, dl_load_s, pend_s, rise_s, fall_s, done_req_s;
    logic [AW-1:0] mem_addr_s;
    logic          mem_we_s;
    logic [7:0]    mem_din_s;

    // Download capture qualifiers and dl_active edge detection
    always_comb begin
        in_range_s = (dl_addr[24:AW] == {HI_W{1'b0}});
        dl_load_s  = dl_wr & ~hv_r & in_range_s;
        // A byte arriving this cycle counts as pending for the starvation guard
        pend_s     = hv_r | dl_load_s;
        rise_s     = dl_active & ~dl_active_d_r;
        fall_s     = ~dl_active & dl_active_d_r;
        done_req_s = (done_pend_r | fall_s) & ~hv_r & (state_r != ST_WR);
    end

    // Arbitration FSM next-state logic: fetches win unless a pending byte has waited through 4 reads
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        starve_s = starve_r;
        case (state_r)
            ST_IDLE: begin
                if (hv_r && (starve_r == STARVE_MAX_C)) begin
                    state_s  = ST_WR;
                    starve_s = 3'd0;
                end else if (rd_req) begin
                    state_s  = ST_RD;
                    cnt_s    = LAT_C;
                    starve_s = pend_s ? (starve_r + 3'd1) : 3'd0;
                end else if (hv_r) begin
                    state_s  = ST_WR;
                    starve_s = 3'd0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == 2'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            ST_WR:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // RAM port drive. In IDLE the fetch address goes out combinationally so that
    // rd_ack arrives MEM_LAT+1 cycles after rd_req.
    always_comb begin
        mem_addr_s = {AW{1'b0}};
        mem_we_s   = 1'b0;
        mem_din_s  = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (state_s == ST_RD) begin
                    mem_addr_s = rd_addr;
                end else begin
                    mem_addr_s = {AW{1'b0}};
                end
            end
            ST_RD:   mem_addr_s = rd_addr_r;
            ST_WR: begin
                mem_addr_s = ha_r;
                mem_we_s   = 1'b1;
                mem_din_s  = hd_r;
            end
            default: mem_addr_s = {AW{1'b0}};
        endcase
    end

    // Next ROM size: cleared at download start, grows to ha+1 when a write commits (AW+1 bits, no wrap)
    always_comb begin
        size_base_s = rise_s ? {(AW+1){1'b0}} : rom_size_r;
        size_cand_s = {1'b0, ha_r} + {{AW{1'b0}}, 1'b1};
        if ((state_r == ST_WR) && (size_cand_s > size_base_s)) begin
            size_next_s = size_cand_s;
        end else begin
            size_next_s = size_base_s;
        end
    end

    // FSM state, fetch countdown and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 2'd0;
            starve_r <= 3'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            starve_r <= starve_s;
        end
    end

    // Holding register: filled by an accepted in-range dl_wr, emptied by the WR cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hv_r <= 1'b0;
            ha_r <= {AW{1'b0}};
            hd_r <= 8'd0;
        end else if (state_r == ST_WR) begin
            hv_r <= 1'b0;
        end else if (dl_load_s) begin
            hv_r <= 1'b1;
            ha_r <= dl_addr[AW-1:0];
            hd_r <= dl_data;
        end
    end

    // Fetch datapath: latch the address at grant, capture RAM data on the last RD cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_r <= {AW{1'b0}};
            rd_ack_r  <= 1'b0;
            rd_data_r <= 8'd0;
        end else begin
            rd_ack_r <= 1'b0;
            if ((state_r == ST_IDLE) && (state_s == ST_RD)) begin
                rd_addr_r <= rd_addr;
            end
            if ((state_r == ST_RD) && (cnt_r == 2'd1)) begin
                rd_ack_r  <= 1'b1;
                rd_data_r <= mem_dout;
            end
        end
    end

    // ROM size tracking and load-done pulse, held back until the pending byte is committed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_size_r    <= {(AW+1){1'b0}};
            dl_active_d_r <= 1'b0;
            done_pend_r   <= 1'b0;
            load_done_r   <= 1'b0;
        end else begin
            rom_size_r    <= size_next_s;
            dl_active_d_r <= dl_active;
            if (rise_s) begin
                done_pend_r <= 1'b0;
                load_done_r <= 1'b0;
            end else if (done_req_s) begin
                done_pend_r <= 1'b0;
                load_done_r <= 1'b1;
            end else begin
                done_pend_r <= done_pend_r | fall_s;
                load_done_r <= 1'b0;
            end
        end
    end

    assign dl_wait   = hv_r;
    assign rd_ack    = rd_ack_r;
    assign rd_data   = rd_data_r;
    assign mem_addr  = mem_addr_s;
    assign mem_we    = mem_we_s;
    assign mem_din   = mem_din_s;
    assign rom_size  = rom_size_r;
    assign load_done = load_done_r;

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Directed bench for rom_dl_arbiter: u1 runs with MEM_LAT=1 and u3 with MEM_LAT=3.
// The two instances share the download inputs and rd_addr; each has its own rd_req and RAM model.
module tb_rom_dl_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [14:0] rd_addr;
    logic        rd_req1, rd_req3;

    logic        dl_wait1, rd_ack1, mem_we1, load_done1;
    logic [7:0]  rd_data1, mem_din1, mem_dout1;
    logic [14:0] mem_addr1;
    logic [15:0] rom_size1;
    logic        dl_wait3, rd_ack3, mem_we3, load_done3;
    logic [7:0]  rd_data3, mem_din3, mem_dout3;
    logic [14:0] mem_addr3;
    logic [15:0] rom_size3;

    logic [7:0]  mem1 [0:32767];
    logic [7:0]  mem3 [0:32767];
    logic [7:0]  p1, q0, q1, q2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wait;
        logic [15:0] exp_size;
        logic [14:0] chk_addr;
        logic [7:0]  chk_byte;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    rom_dl_arbiter #(.AW(15), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
        .dl_data(dl_data), .dl_wait(dl_wait1), .rd_req(rd_req1), .rd_addr(rd_addr),
        .rd_ack(rd_ack1), .rd_data(rd_data1), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_din(mem_din1), .mem_dout(mem_dout1), .rom_size(rom_size1), .load_done(load_done1)
    );

    rom_dl_arbiter #(.AW(15), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
        .dl_data(dl_data), .dl_wait(dl_wait3), .rd_req(rd_req3), .rd_addr(rd_addr),
        .rd_ack(rd_ack3), .rd_data(rd_data3), .mem_addr(mem_addr3), .mem_we(mem_we3),
        .mem_din(mem_din3), .mem_dout(mem_dout3), .rom_size(rom_size3), .load_done(load_done3)
    );

    // RAM model with a one-cycle read latency
    always @(posedge clk) begin
        if (mem_we1) mem1[mem_addr1] <= mem_din1;
        p1 <= mem1[mem_addr1];
    end
    assign mem_dout1 = p1;

    // RAM model with a three-cycle read latency
    always @(posedge clk) begin
        if (mem_we3) mem3[mem_addr3] <= mem_din3;
        q0 <= mem3[mem_addr3];
        q1 <= q0;
        q2 <= q1;
    end
    assign mem_dout3 = q2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wait, with a cycle bound, until both holding registers are empty
    task automatic wait_ready();
        int n;
        n = 0;
        while ((dl_wait1 || dl_wait3) && n < 20) begin
            step();
            n++;
        end
        chk("wait_ready_bound", {31'd0, dl_wait1 | dl_wait3}, 32'd0);
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        wait_ready();
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        step();
        dl_wr   = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [11:0] v;
        v = 12'(i);
        return v[7:0] ^ {v[11:8], v[7:4]};
    endfunction

    initial begin
        logic [7:0] old;
        int bad, waits, acks, writes, since, gap_bad, issued, lat1, lat3;

        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'd0;
        rd_addr = 15'd0; rd_req1 = 1'b0; rd_req3 = 1'b0;
        step();
        chk("rst_dl_wait", {31'd0, dl_wait1}, 32'd0);
        chk("rst_rd_ack", {31'd0, rd_ack1}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data1}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we1}, 32'd0);
        chk("rst_mem_addr", {17'd0, mem_addr1}, 32'd0);
        chk("rst_rom_size", {16'd0, rom_size1}, 32'd0);
        chk("rst_load_done", {31'd0, load_done1}, 32'd0);
        reset = 1'b0;
        step();

        // reset asserted while a byte is in WR
        dl_active = 1'b1;
        step();
        dl_byte(25'h5, 8'h3C);
        wait_ready();
        step();
        chk("t1_size_before", {16'd0, rom_size1}, 32'd6);
        old = mem1[15'h1000];
        dl_byte(25'h1000, ~old);
        step();
        chk("t1_in_wr", {31'd0, mem_we1}, 32'd1);
        reset = 1'b1;
        dl_active = 1'b0;
        #1;
        chk("t1_mem_we", {31'd0, mem_we1}, 32'd0);
        chk("t1_dl_wait", {31'd0, dl_wait1}, 32'd0);
        chk("t1_rom_size", {16'd0, rom_size1}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t1_not_written", {24'd0, mem1[15'h1000]}, {24'd0, old});
        chk("t1_wait_after", {31'd0, dl_wait1}, 32'd0);

        // 4096-byte download with no fetches
        dl_active = 1'b1;
        step();
        waits = 0;
        for (int i = 0; i < 4096; i++) begin
            dl_byte(25'(i), pat(i));
            if (dl_wait1) waits++;
            step();
        end
        chk("t2_wait_pulses", 32'(waits), 32'd4096);
        wait_ready();
        dl_active = 1'b0;
        step();
        chk("t2_load_done", {31'd0, load_done1}, 32'd1);
        chk("t2_rom_size", {16'd0, rom_size1}, 32'd4096);
        step();
        chk("t2_load_done_once", {31'd0, load_done1}, 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem1[i] !== pat(i)) bad++;
        chk("t2_ram_bad", 32'(bad), 32'd0);

        // table: rom_size growth, no wrap, out-of-range addresses ignored
        vecs[0] = '{25'h0000000, 8'hA5, 1'b1, 16'h0001, 15'h0000, 8'hA5};
        vecs[1] = '{25'h0007FFF, 8'h5A, 1'b1, 16'h8000, 15'h7FFF, 8'h5A};
        vecs[2] = '{25'h0000010, 8'h11, 1'b1, 16'h8000, 15'h0010, 8'h11};
        vecs[3] = '{25'h0008000, 8'h77, 1'b0, 16'h8000, 15'h0000, 8'hA5};
        vecs[4] = '{25'h1FF0100, 8'hEE, 1'b0, 16'h8000, 15'h0010, 8'h11};
        vecs[5] = '{25'h0000100, 8'h22, 1'b1, 16'h8000, 15'h0100, 8'h22};
        dl_active = 1'b1;
        step();
        chk("t5_size_cleared", {16'd0, rom_size1}, 32'd0);
        for (int v = 0; v < 6; v++) begin
            wait_ready();
            dl_wr = 1'b1; dl_addr = vecs[v].addr; dl_data = vecs[v].data;
            step();
            dl_wr = 1'b0;
            chk($sformatf("t5_wait_%0d", v), {31'd0, dl_wait1}, {31'd0, vecs[v].exp_wait});
            step(); step(); step();
            chk($sformatf("t5_size_%0d", v), {16'd0, rom_size1}, {16'd0, vecs[v].exp_size});
            chk($sformatf("t5_ram_%0d", v), {24'd0, mem1[vecs[v].chk_addr]}, {24'd0, vecs[v].chk_byte});
        end

        // rd_req and a pending byte in the same IDLE cycle: read first, then WR
        rd_addr = 15'h0010;
        wait_ready();
        dl_wr = 1'b1; dl_addr = 25'h300; dl_data = 8'h4B;
        step();
        dl_wr = 1'b0;
        rd_req1 = 1'b1;
        #1;
        chk("t4_hv_wait", {31'd0, dl_wait1}, 32'd1);
        chk("t4_we_c1", {31'd0, mem_we1}, 32'd0);
        chk("t4_rd_addr", {17'd0, mem_addr1}, 32'h10);
        step();
        chk("t4_ack_c2", {31'd0, rd_ack1}, 32'd0);
        chk("t4_we_c2", {31'd0, mem_we1}, 32'd0);
        step();
        chk("t4_ack_c3", {31'd0, rd_ack1}, 32'd1);
        chk("t4_data", {24'd0, rd_data1}, 32'h11);
        rd_req1 = 1'b0;
        #1;
        chk("t4_we_c3", {31'd0, mem_we1}, 32'd0);
        step();
        chk("t4_we_c4", {31'd0, mem_we1}, 32'd1);
        chk("t4_wr_addr", {17'd0, mem_addr1}, 32'h300);
        chk("t4_wr_din", {24'd0, mem_din1}, 32'h4B);
        step();
        chk("t4_ram", {24'd0, mem1[15'h300]}, 32'h4B);

        // continuous fetches and a download stream: WR every 5th grant
        rd_addr = 15'h0100;
        acks = 0; writes = 0; since = 0; gap_bad = 0; bad = 0;
        rd_req1 = 1'b1;
        dl_wr = 1'b1; dl_addr = 25'h2000; dl_data = 8'd0; issued = 1;
        for (int c = 0; c < 400 && writes < 8; c++) begin
            step();
            if (rd_ack1) begin
                acks++; since++;
                if (rd_data1 !== 8'h22) bad++;
            end
            if (mem_we1) begin
                writes++;
                if (since != 4) gap_bad++;
                since = 0;
                if (writes == 8) rd_req1 = 1'b0;
            end
            if (dl_wr) begin
                dl_wr = 1'b0;
            end else if (!dl_wait1 && writes < 8) begin
                dl_wr = 1'b1; dl_addr = 25'h2000 + 25'(issued); dl_data = 8'(issued);
                issued++;
            end
        end
        dl_wr = 1'b0;
        chk("t3_writes", 32'(writes), 32'd8);
        chk("t3_issued", 32'(issued), 32'd8);
        chk("t3_acks", 32'(acks), 32'd32);
        chk("t3_gap_bad", 32'(gap_bad), 32'd0);
        chk("t3_rd_data_bad", 32'(bad), 32'd0);
        step(); step(); step();
        chk("t3_no_extra_ack", {31'd0, rd_ack1}, 32'd0);
        bad = 0;
        for (int k = 0; k < 8; k++) if (mem1[15'h2000 + 15'(k)] !== 8'(k)) bad++;
        chk("t3_ram_bad", 32'(bad), 32'd0);

        // MEM_LAT 1 and 3: load 0x1234, load_done deferred behind the pending byte, fetch latency
        reset = 1'b1;
        dl_active = 1'b0;
        step();
        reset = 1'b0;
        dl_active = 1'b1;
        step();
        dl_byte(25'h1234, 8'hC3);
        dl_active = 1'b0;
        step();
        chk("t6_ld_c2", {31'd0, load_done1}, 32'd0);
        step();
        chk("t6_ld_c3", {31'd0, load_done1}, 32'd0);
        step();
        chk("t6_ld_c4", {31'd0, load_done1}, 32'd1);
        chk("t6_size1", {16'd0, rom_size1}, 32'h1235);
        chk("t6_ld3_c4", {31'd0, load_done3}, 32'd1);
        chk("t6_size3", {16'd0, rom_size3}, 32'h1235);
        step();
        chk("t6_ld_c5", {31'd0, load_done1}, 32'd0);
        rd_addr = 15'h1234;
        rd_req1 = 1'b1; rd_req3 = 1'b1;
        lat1 = 0; lat3 = 0;
        for (int c = 1; c <= 10 && (rd_req1 || rd_req3); c++) begin
            step();
            if (rd_req1 && rd_ack1) begin
                lat1 = c; rd_req1 = 1'b0;
                chk("t6_data1", {24'd0, rd_data1}, 32'hC3);
            end
            if (rd_req3 && rd_ack3) begin
                lat3 = c; rd_req3 = 1'b0;
                chk("t6_data3", {24'd0, rd_data3}, 32'hC3);
            end
        end
        rd_req1 = 1'b0; rd_req3 = 1'b0;
        chk("t6_lat1", 32'(lat1), 32'd2);
        chk("t6_lat3", 32'(lat3), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
